// File: rtl/apb_pkg.sv
// Shared APB definitions: bus width defaults, completer FSM states and the
// misalignment/range check used when a transfer is accepted.
package apb_pkg;

    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_ADDR_W = 32;

    typedef enum logic {
        StIdle   = 1'b0,
        StAccess = 1'b1
    } apb_state_e;

    // Flags a local byte offset that is not word aligned or lies beyond the array.
    function automatic logic apb_err_f(input logic [31:0] offs, input int unsigned depth);
        return (offs[1:0] != 2'b00) || (offs >= (32'(depth) << 2));
    endfunction

endpackage

// File: rtl/apb_mem_bank.sv
// Word array with asynchronous clear, byte-strobed write port and a registered
// read port whose output holds until the next load or clear.
module apb_mem_bank
    import apb_pkg::*;
#(
    parameter int unsigned DATA_W = APB_DATA_W,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb,
    input  logic                  rd_en,
    input  logic                  rd_clr,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_W-1:0]     rd_data
);

    localparam int unsigned STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                    mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Clear takes priority so an errored read returns zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_clr) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_idx];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer fronting a word-addressed memory, with a fixed number of
// wait states per ACCESS phase and PSLVERR on misaligned or out-of-range offsets.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int unsigned DATA_W      = APB_DATA_W,
    parameter int unsigned ADDR_W      = APB_ADDR_W,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned OFFS_W      = 8,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_W-1:0]     PADDR,
    input  logic [DATA_W-1:0]     PWDATA,
    input  logic [DATA_W/8-1:0]   PSTRB,
    output logic                  PREADY,
    output logic [DATA_W-1:0]     PRDATA,
    output logic                  PSLVERR
);

    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    apb_state_e          state_q;
    logic [OFFS_W-1:0]   offs_q;
    logic                write_q;
    logic                err_q;
    logic                ready_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic [3:0]          cnt_q;

    logic [OFFS_W-1:0]   offs_in;
    logic                setup;
    logic                err_in;
    logic                complete;
    logic                mem_wr_en;
    logic                mem_rd_en;
    logic                mem_rd_clr;

    assign offs_in  = PADDR[OFFS_W-1:0];
    assign setup    = (state_q == StIdle) && PSEL && !PENABLE;
    assign err_in   = apb_err_f(32'(offs_in), DEPTH);
    assign complete = (state_q == StAccess) && PSEL && PENABLE && ready_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= StIdle;
            offs_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    // PENABLE high without a prior SETUP falls through and is ignored.
                    if (setup) begin
                        offs_q  <= offs_in;
                        write_q <= PWRITE;
                        wdata_q <= PWDATA;
                        strb_q  <= PSTRB;
                        err_q   <= err_in;
                        cnt_q   <= WAIT_INIT;
                        ready_q <= (WAIT_INIT == 4'd0);
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    if (!PSEL) begin
                        state_q <= StIdle;
                        ready_q <= 1'b0;
                        cnt_q   <= '0;
                    end else if (PENABLE) begin
                        if (ready_q) begin
                            state_q <= StIdle;
                            ready_q <= 1'b0;
                        end else if (cnt_q != 4'd0) begin
                            cnt_q   <= cnt_q - 4'd1;
                            ready_q <= (cnt_q == 4'd1);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_wr_en  = complete && write_q && !err_q;
    assign mem_rd_en  = setup && !PWRITE && !err_in;
    assign mem_rd_clr = setup && !PWRITE && err_in;

    apb_mem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .wr_en   (mem_wr_en),
        .wr_idx  (offs_q[IDX_W+1:2]),
        .wr_data (wdata_q),
        .wr_strb (strb_q),
        .rd_en   (mem_rd_en),
        .rd_clr  (mem_rd_clr),
        .rd_idx  (offs_in[IDX_W+1:2]),
        .rd_data (PRDATA)
    );

    assign PREADY  = ready_q;
    assign PSLVERR = ready_q & err_q;

    // Upper PADDR bits are decoded by the master; the low offset bits are
    // only partly used for indexing.
    logic unused_bits;
    assign unused_bits = ^{offs_q, PADDR};

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances (zero-wait, two-wait, three-wait
// with a half-size array) on a shared bus, checked against a byte-lane memory model.
module tb_apb_slave_mem;

    logic        PCLK;
    logic        PRESETn;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pready;
    logic [2:0]  pslverr;
    logic [31:0] prdata [3];

    int checks = 0;
    int errors = 0;

    int unsigned depth_of [3] = '{64, 64, 32};
    int unsigned wait_of  [3] = '{0, 2, 3};
    logic [31:0] model [3][64];

    apb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));
    apb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(2)) dut1 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));
    apb_slave_mem #(.DEPTH(32), .WAIT_CYCLES(3)) dut2 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[2]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Reference model: byte-addressed rules straight from the bus contract.
    function automatic logic ref_err(input int idx, input logic [31:0] addr);
        int unsigned off;
        off = addr % 256;
        return ((off % 4) != 0) || (off >= depth_of[idx] * 4);
    endfunction

    function automatic logic [31:0] ref_read(input int idx, input logic [31:0] addr);
        if (ref_err(idx, addr)) return 32'h0;
        return model[idx][(addr % 256) / 4];
    endfunction

    task automatic ref_write(input int idx, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        int unsigned w;
        if (ref_err(idx, addr)) return;
        w = (addr % 256) / 4;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[idx][w][b*8 +: 8] = data[b*8 +: 8];
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 64; j++) model[i][j] = 32'h0;
    endtask

    // One full transfer; leaves the bus idle right after the completion edge.
    task automatic xfer(input int idx, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        output logic [31:0] rdata, output logic slverr, output int nwait);
        bit done;
        psel = 3'b000;
        psel[idx] = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = addr;
        pwdata = wdata;
        pstrb = strb;
        @(posedge PCLK); #1;
        penable = 1'b1;
        nwait = 0;
        done = 1'b0;
        rdata = 32'hx;
        slverr = 1'bx;
        for (int c = 0; c < 40 && !done; c++) begin
            if (pready[idx] === 1'b1) begin
                rdata = prdata[idx];
                slverr = pslverr[idx];
                done = 1'b1;
            end else begin
                nwait++;
                @(posedge PCLK); #1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: inst %0d addr %h no PREADY within 40 cycles", idx, addr);
        end
        @(posedge PCLK); #1;
        psel = 3'b000;
        penable = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        model_clear();
        repeat (3) @(posedge PCLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pready[i] !== 1'b0 || pslverr[i] !== 1'b0 || prdata[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs: inst %0d got ready=%b err=%b rdata=%h want 0/0/0",
                         i, pready[i], pslverr[i], prdata[i]);
            end
        end
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic se; int nw;
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, se, nw);
        ref_write(0, 32'h10, 32'hDEADBEEF, 4'hF);
        checks++;
        if (nw !== 0 || se !== 1'b0) begin
            errors++;
            $display("FAIL basic_write: got waits=%0d err=%b want 0/0", nw, se);
        end
        checks++;
        if (pready[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_ready_drop: got %b want 0", pready[0]);
        end
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, se, nw);
        checks++;
        if (rd !== 32'hDEADBEEF || se !== 1'b0 || nw !== 0) begin
            errors++;
            $display("FAIL basic_read: got %h err=%b waits=%0d want deadbeef/0/0", rd, se, nw);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic se; int nw;
        xfer(1, 1'b1, 32'h110, 32'hCAFEBABE, 4'hF, rd, se, nw);
        ref_write(1, 32'h110, 32'hCAFEBABE, 4'hF);
        checks++;
        if (nw !== 2 || se !== 1'b0) begin
            errors++;
            $display("FAIL wait_write: got waits=%0d err=%b want 2/0", nw, se);
        end
        xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, se, nw);
        checks++;
        if (rd !== 32'hCAFEBABE || nw !== 2) begin
            errors++;
            $display("FAIL wait_read: got %h waits=%0d want cafebabe/2", rd, nw);
        end
    endtask

    task automatic test_partial();
        logic [31:0] rd; logic se; int nw;
        xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, se, nw);
        ref_write(0, 32'h20, 32'h11223344, 4'hF);
        xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0011, rd, se, nw);
        ref_write(0, 32'h20, 32'hAABBCCDD, 4'b0011);
        xfer(0, 1'b0, 32'h20, 32'hFFFFFFFF, 4'hF, rd, se, nw);
        checks++;
        if (rd !== 32'h1122CCDD) begin
            errors++;
            $display("FAIL partial_read: got %h want 1122ccdd", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic se; int nw;
        xfer(0, 1'b1, 32'h12, 32'h99999999, 4'hF, rd, se, nw);
        checks++;
        if (se !== 1'b1) begin
            errors++;
            $display("FAIL err_misaligned_write: got pslverr=%b want 1", se);
        end
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, se, nw);
        checks++;
        if (rd !== ref_read(0, 32'h10) || se !== 1'b0) begin
            errors++;
            $display("FAIL err_misaligned_nowrite: got %h err=%b want %h/0",
                     rd, se, ref_read(0, 32'h10));
        end
        xfer(0, 1'b0, 32'h12, 32'h0, 4'h0, rd, se, nw);
        checks++;
        if (rd !== 32'h0 || se !== 1'b1) begin
            errors++;
            $display("FAIL err_misaligned_read: got %h err=%b want 0/1", rd, se);
        end
        // 0xFC aliases word 31 of the 32-word array if the range check is lost.
        xfer(2, 1'b1, 32'h7C, 32'h0F0F0F0F, 4'hF, rd, se, nw);
        ref_write(2, 32'h7C, 32'h0F0F0F0F, 4'hF);
        xfer(2, 1'b1, 32'hFC, 32'hA5A5A5A5, 4'hF, rd, se, nw);
        checks++;
        if (se !== 1'b1 || nw !== 3) begin
            errors++;
            $display("FAIL err_range_write: got err=%b waits=%0d want 1/3", se, nw);
        end
        xfer(2, 1'b0, 32'h7C, 32'h0, 4'h0, rd, se, nw);
        checks++;
        if (rd !== 32'h0F0F0F0F || se !== 1'b0) begin
            errors++;
            $display("FAIL err_range_nowrite: got %h err=%b want 0f0f0f0f/0", rd, se);
        end
        xfer(2, 1'b0, 32'hFC, 32'h0, 4'h0, rd, se, nw);
        checks++;
        if (rd !== 32'h0 || se !== 1'b1) begin
            errors++;
            $display("FAIL err_range_read: got %h err=%b want 0/1", rd, se);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic se; int nw;
        xfer(2, 1'b1, 32'h08, 32'h12345678, 4'hF, rd, se, nw);
        ref_write(2, 32'h08, 32'h12345678, 4'hF);
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h08; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(posedge PCLK); #1;
        psel = 3'b000; penable = 1'b0;
        @(posedge PCLK); #1;
        checks++;
        if (pready[2] !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready: got %b want 0", pready[2]);
        end
        // ACCESS without SETUP must be ignored.
        psel = 3'b100; penable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge PCLK); #1;
            checks++;
            if (pready[2] !== 1'b0) begin
                errors++;
                $display("FAIL nosetup_ready: cycle %0d got %b want 0", c, pready[2]);
            end
        end
        psel = 3'b000; penable = 1'b0;
        xfer(2, 1'b0, 32'h08, 32'h0, 4'h0, rd, se, nw);
        checks++;
        if (rd !== 32'h12345678 || nw !== 3) begin
            errors++;
            $display("FAIL abort_nowrite: got %h waits=%0d want 12345678/3", rd, nw);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic se; int nw;
        xfer(0, 1'b1, 32'h10, 32'h0BADF00D, 4'hF, rd, se, nw);
        psel = 3'b001; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
        @(posedge PCLK); #1;
        penable = 1'b1;
        checks++;
        if (pready[0] !== 1'b1 || prdata[0] !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL resetmid_pre: got ready=%b rdata=%h want 1/0badf00d",
                     pready[0], prdata[0]);
        end
        #2 PRESETn = 1'b0;
        #1;
        checks++;
        if (pready[0] !== 1'b0 || pslverr[0] !== 1'b0 || prdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL resetmid_async: got ready=%b err=%b rdata=%h want 0/0/0",
                     pready[0], pslverr[0], prdata[0]);
        end
        psel = 3'b000; penable = 1'b0;
        model_clear();
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, se, nw);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL resetmid_mem0: got %h want 0", rd);
        end
        xfer(1, 1'b0, 32'h110, 32'h0, 4'h0, rd, se, nw);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL resetmid_mem1: got %h want 0", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic se; int nw;
        xfer(0, 1'b1, 32'h04, 32'h5, 4'hF, rd, se, nw);
        ref_write(0, 32'h04, 32'h5, 4'hF);
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, se, nw);
        checks++;
        if (rd !== 32'h00000005 || se !== 1'b0 || nw !== 0) begin
            errors++;
            $display("FAIL b2b_read: got %h err=%b waits=%0d want 00000005/0/0", rd, se, nw);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, data, exp; logic se, eerr; int nw, idx; bit wr; logic [3:0] strb;
        for (int n = 0; n < 300; n++) begin
            idx = int'($urandom_range(0, 2));
            wr = 1'($urandom_range(0, 1));
            addr = {$urandom} & 32'hFFFFFF00;
            if ($urandom_range(0, 7) == 0) addr[7:0] = 8'($urandom_range(0, 255));
            else addr[7:0] = 8'($urandom_range(0, 63) * 4);
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            eerr = ref_err(idx, addr);
            exp = ref_read(idx, addr);
            xfer(idx, wr, addr, data, strb, rd, se, nw);
            if (wr) ref_write(idx, addr, data, strb);
            checks++;
            if (se !== eerr || nw !== int'(wait_of[idx])) begin
                errors++;
                $display("FAIL rand_resp: n=%0d inst %0d addr %h got err=%b waits=%0d want %b/%0d",
                         n, idx, addr, se, nw, eerr, wait_of[idx]);
            end
            if (!wr) begin
                checks++;
                if (rd !== exp) begin
                    errors++;
                    $display("FAIL rand_rdata: n=%0d inst %0d addr %h got %h want %h",
                             n, idx, addr, rd, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_partial();
        test_errors();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
APB4 completer (slave) with a word-addressed register memory, programmable wait states and error signalling. It sits directly downstream of the APB master inside APB_TOP, one instance per PSEL line (slave 0 at 0x000–0x0FF, slave 1 at 0x100–0x1FF). It consumes the master's SETUP/ACCESS phases and returns PREADY, PRDATA and PSLVERR.

Parameters:
DATA_W, 32, data bus width (fixed 32; PSTRB is DATA_W/8)
ADDR_W, 32, PADDR width
DEPTH, 64, number of 32-bit words; local byte offset range 0..DEPTH*4-1
OFFS_W, 8, low PADDR bits used as local offset; upper bits ignored (master decodes PSEL)
WAIT_CYCLES, 0, PREADY-low cycles inserted in every ACCESS phase (0..15)

Ports:
PCLK  in  1  clock, rising edge
PRESETn  in  1  asynchronous active-low reset
PSEL  in  1  slave select from master
PENABLE  in  1  ACCESS-phase indicator
PWRITE  in  1  1 = write, 0 = read
PADDR  in  ADDR_W  byte address
PWDATA  in  DATA_W  write data
PSTRB  in  DATA_W/8  byte write strobes
PREADY  out  1  transfer-complete
PRDATA  out  DATA_W  read data, valid when PREADY=1 and PWRITE=0
PSLVERR  out  1  error response, valid only when PREADY=1

Behaviour:
- Reset (async, PRESETn=0): state=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, wait counter=0, all memory words=0. Takes effect immediately, mid-transfer included; a pending write is discarded.
- FSM states: IDLE, ACCESS.
- IDLE: on PSEL=1 and PENABLE=0 (SETUP), latch PADDR[OFFS_W-1:0], PWRITE, PWDATA, PSTRB; set cnt=WAIT_CYCLES; compute err; if read and !err, load PRDATA<=mem[offset>>2]; go to ACCESS.
- err = (PADDR[1:0]!=0) or (offset >= DEPTH*4).
- ACCESS: PREADY = (cnt==0), from registers only, no combinational path from inputs. While PENABLE=1 and cnt!=0, decrement cnt.
- Completion is the cycle with PSEL=1, PENABLE=1 and PREADY=1. On the following edge: if write and !err, update each byte lane i with PSTRB[i]=1; then go to IDLE. PREADY drops to 0 the next cycle.
- Reads ignore PSTRB. An errored read returns PRDATA=0. An errored write leaves memory unchanged.
- PSLVERR = err latched AND PREADY; otherwise 0.
- Latency: SETUP + (WAIT_CYCLES+1) ACCESS cycles. WAIT_CYCLES=0 gives a 2-cycle zero-wait transfer.
- Back-to-back: a new SETUP directly after completion is accepted. A read immediately after a write to the same address returns the new data.
- PSEL=0 while in ACCESS (protocol abort): return to IDLE, PREADY=0, no memory update.
- PSEL=1 with PENABLE=1 while in IDLE (no SETUP seen): ignored; remain in IDLE, PREADY=0.
- PRDATA holds its last value between transfers.

Decomposition:
- Package apb_pkg: APB state enum (IDLE/ACCESS), DATA_W/ADDR_W defaults, and an apb_err_f function (misalign/range check). The master shares these.
- One natural sub-module, apb_mem_bank: DEPTH x DATA_W array with async clear, byte-strobed write port and registered read port. The FSM, wait counter and error logic stay in apb_slave_mem.

Test Plan:
1. WAIT_CYCLES=0: write 0xDEADBEEF to PADDR 0x10 with PSTRB=4'hF, then read 0x10 → PREADY high in the first ACCESS cycle, PRDATA=0xDEADBEEF, PSLVERR=0.
2. WAIT_CYCLES=2: write 0xCAFEBABE to 0x110 → PREADY low for exactly 2 ACCESS cycles, high on the 3rd; read-back of offset 0x10 = 0xCAFEBABE.
3. Partial write: mem[0x20]=0x11223344, then write 0xAABBCCDD with PSTRB=4'b0011 → read 0x20 returns 0x1122CCDD.
4. Errors: write to 0x12 (misaligned) and to 0xFC with DEPTH=32 (out of range) → PSLVERR=1 with PREADY, memory unchanged; errored read returns PRDATA=0.
5. Abort and reset: drop PSEL mid-ACCESS with WAIT_CYCLES=3 → no write, FSM in IDLE. Assert PRESETn=0 mid-transfer → PREADY, PSLVERR and PRDATA go 0 immediately; reading 0x10 afterwards returns 0.
6. Back-to-back write 0x5 to 0x04 followed by read of 0x04 with no idle cycle → read returns 0x00000005.
